fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the control unit and decoder.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake that tolerates variable latency.
- Presents the fetched instruction, its PC and PC+4 to decode through an IF/ID register that has a one-entry skid buffer.
- Takes redirects from the branch decision (PCSrc), with flush and drop of in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INSTR, 32'h0000_0013, value on instr_o whenever valid_o=0 (addi x0,x0,0).

Ports:
- clk_i  input  1  clock; everything updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- PCSrc_i  input  1  taken-branch redirect for the instruction currently on valid_o.
- PCTarget_i  input  32  redirect target; bits [1:0] ignored.
- stall_i  input  1  decode cannot accept; IF/ID holds.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  word address, [1:0]=00; stable while req_o & ~gnt_i.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid; earliest the cycle after gnt.
- imem_rdata_i  input  32  instruction word.
- instr_o  output  32  IF/ID instruction.
- pc_o  output  32  PC of instr_o.
- pc_plus4_o  output  32  pc_o+4, mod 2^32.
- valid_o  output  1  IF/ID holds a live instruction.

Behaviour:
- Reset (any cycle, including mid-request):
  - pc_q=RESET_PC, state=FETCH, drop_q=0, skid empty.
  - valid_o=0, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=4, imem_req_o=0 in the cycle rst_i is high.
  - Any response that arrives after reset is ignored.
- FSM states FETCH, WAIT:
  - FETCH: imem_req_o=1 iff the skid buffer is empty. imem_addr_o = req_addr_q, latched from pc_q on entry and held until gnt. On gnt -> WAIT.
  - WAIT: imem_req_o=0. On rvalid -> FETCH next cycle.
  - At most one outstanding request. With 1-cycle memory, throughput is 1 instruction per 2 cycles.
- Response handling (rvalid in WAIT, drop_q=0):
  - pc_q <= req_addr_q+4.
  - If IF/ID is empty or consumed this cycle (valid_o & ~stall_i): load IF/ID with {rdata, req_addr_q}, valid_o=1.
  - Otherwise load the skid buffer.
  - The skid buffer drains into IF/ID on the first cycle IF/ID is consumed. IF/ID is always loaded from the skid before any newer response, so order is preserved.
- Consume: valid_o & ~stall_i with nothing to load -> valid_o=0, instr_o=NOP_INSTR.
- Redirect (PCSrc_i & valid_o; PCSrc_i ignored when valid_o=0):
  - Next cycle: valid_o=0, skid emptied, pc_q=PCTarget_i & ~3.
  - If a request is granted but not yet returned (WAIT), or rvalid arrives in the redirect cycle: that response is discarded. Use drop_q when the response arrives later.
  - If req is ungranted in FETCH: the request to the old address completes, drop_q=1, and its data is discarded. The next FETCH latches the new pc_q.
  - Redirect overrides stall_i and any simultaneous load.
- rvalid with drop_q=1: drop_q<=0, pc_q is not advanced, nothing is loaded.
- PC wrap: 32'hFFFF_FFFC+4 = 0. pc_plus4_o is computed the same way.
- stall_i with valid_o=0 has no effect on IF/ID.
- Protocol assertions (bench):
  - no rvalid outside WAIT;
  - imem_addr_o stable while req & ~gnt;
  - imem_addr_o[1:0]==0.

Decomposition:
- Shared package (e.g. riscv_pkg): NOP_INSTR constant, RESET_PC default, fetch_state_t enum {FETCH, WAIT}, and a fetch_entry_t struct {instr, pc}, used for both IF/ID and the skid buffer.
- One sub-module: fetch_skid_buf, a one-entry buffer with valid, load, drain and flush.
- The FSM, PC register and drop logic stay in fetch_stage.

Test Plan:
- Reset then 1-cycle memory returning 0x00500093, 0x00A00113 -> valid_o pulses. pc_o=0x0 then 0x4, pc_plus4_o=0x4 then 0x8, imem_addr_o sequence 0x0, 0x4, 0x8.
- stall_i held 6 cycles while valid_o=1 at pc 0x4, memory keeps answering:
  - IF/ID stays at pc 0x4;
  - the pc 0x8 response is parked in the skid;
  - imem_req_o=0 while the skid is full;
  - on release, pc 0x4, 0x8, 0xC appear in order with no loss or duplication.
- PCSrc_i=1, PCTarget_i=0x100 while WAIT on 0x10 (rvalid 3 cycles later):
  - valid_o=0 next cycle;
  - the 0x10 data is never shown;
  - next imem_addr_o=0x100, then pc_o=0x100.
- Redirect to 0x203 while req to 0x20 is ungranted (gnt 2 cycles later):
  - addr stays 0x20 until gnt;
  - the response is dropped;
  - next fetch is 0x200.
- rst_i asserted while WAIT, rvalid arrives the cycle after reset releases -> response ignored, first fetch is RESET_PC, valid_o=0 throughout reset.
- Redirect to 0xFFFF_FFFC -> pc_plus4_o=0x0 and the following fetch address is 0x0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   DEF_NOP_INSTR  : bubble shown to decode when nothing is valid (addi x0,x0,0)
//   DEF_RESET_PC   : default first fetch address after reset
//   fetch_state_t  : FETCH (request phase) / WAIT (one request outstanding)
//   fetch_entry_t  : {instr, pc}, used for both the IF/ID register and the skid entry
package fetch_stage_pkg;

    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// One-entry skid buffer parking a fetched word while IF/ID is held by decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : discard the entry (wins over load/drain)
//   load_i       : capture data_i
//   drain_i      : entry has been moved into IF/ID
//   data_i       : entry to capture
//   valid_o      : entry held
//   data_o       : held entry
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         drain_i,
    input  fetch_entry_t data_i,
    output logic         valid_o,
    output fetch_entry_t data_o
);

    logic         valid_q, valid_d;
    fetch_entry_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM,
// IF/ID register backed by a one-entry skid buffer, and redirect/drop handling.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   PCSrc_i, PCTarget_i   : taken-branch redirect for the instruction on valid_o
//   stall_i               : decode holds IF/ID
//   imem_req_o/addr_o     : word read request (addr held until gnt)
//   imem_gnt_i            : request accepted
//   imem_rvalid_i/rdata_i : read response
//   instr_o, pc_o, pc_plus4_o, valid_o : IF/ID outputs to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PCSrc_i,
    input  logic [31:0] PCTarget_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         drop_q, drop_d;
    fetch_entry_t ifid_q, ifid_d;
    logic         ifid_vld_q, ifid_vld_d;

    logic         skid_vld, skid_load, skid_drain, skid_flush;
    fetch_entry_t skid_data, resp_entry;
    logic         fetch_req, redirect, consume, resp_ok;

    // No new request while a parked word waits: keeps at most one word
    // beyond IF/ID, so a response never finds the skid occupied.
    assign fetch_req  = (state_q == FETCH) && !skid_vld;
    assign redirect   = PCSrc_i && ifid_vld_q;
    assign consume    = ifid_vld_q && !stall_i;
    assign resp_ok    = (state_q == WAIT) && imem_rvalid_i && !drop_q && !redirect;
    assign resp_entry = '{instr: imem_rdata_i, pc: req_addr_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        ifid_d     = ifid_q;
        ifid_vld_d = ifid_vld_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        case (state_q)
            FETCH: begin
                if (fetch_req && imem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                    if (drop_q) drop_d = 1'b0;             // stale word, PC untouched
                    else        pc_d   = req_addr_q + 32'd4;
                end
            end
            default: state_d = FETCH;
        endcase

        // IF/ID: a parked word always goes first, so order is preserved.
        if (consume) begin
            if (skid_vld) begin
                ifid_d     = skid_data;
                skid_drain = 1'b1;
            end else begin
                ifid_vld_d = 1'b0;
            end
        end
        if (resp_ok) begin
            if (!ifid_vld_q || consume) begin
                ifid_d     = resp_entry;
                ifid_vld_d = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end

        // Redirect wins over stall and any load. A request that is already
        // issued (granted, or still waiting for gnt) must complete, so its
        // data is marked for dropping unless it returns right now.
        if (redirect) begin
            ifid_vld_d = 1'b0;
            skid_flush = 1'b1;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            pc_d       = PCTarget_i & 32'hFFFF_FFFC;
            if ((state_q == WAIT && !imem_rvalid_i) || (state_q == FETCH && fetch_req))
                drop_d = 1'b1;
        end

        // Address is captured whenever FETCH is (re)entered or idle; it is
        // frozen only while a request is on the bus awaiting gnt.
        if (state_d == FETCH && !(fetch_req && !imem_gnt_i))
            req_addr_d = pc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            ifid_q     <= '{instr: NOP_INSTR, pc: 32'h0};
            ifid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            ifid_q     <= ifid_d;
            ifid_vld_q <= ifid_vld_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (skid_flush),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .data_i  (resp_entry),
        .valid_o (skid_vld),
        .data_o  (skid_data)
    );

    // Outputs are forced quiet during the reset cycle itself, not just after it.
    assign imem_req_o  = fetch_req && !rst_i;
    assign imem_addr_o = req_addr_q;
    assign valid_o     = ifid_vld_q && !rst_i;
    assign instr_o     = valid_o ? ifid_q.instr : NOP_INSTR;
    assign pc_o        = rst_i ? 32'h0 : ifid_q.pc;
    assign pc_plus4_o  = pc_o + 32'd4;

endmodule
